afe2256_spi_target: RTL and testbench
=====================================

# afe2256_spi_target

Behavioural-synthesizable SPI target that models the AFE2256 register interface: the responder at the far end of the `afe2256_spi_controller` link. It receives 24-bit frames (8-bit address, 16-bit data, MSB first, CPOL=0/CPHA=0) on the SPI pins, oversamples them in the system clock domain, and updates a 256 x 16 register file. It drives readback data on SDO when read mode is enabled and exposes a host-side debug read port. It sits in loopback benches and in the FPGA-only ROIC emulator that replaces a physical AFE2256.

## Interface
- `CLK_FREQ_MHZ`, 100: system clock frequency. Must be ≥ 8 × SCK frequency.
- `RO_MASK_ADDR`, 8'hFF: address treated as read-only. Writes to it are dropped.

- `clk`  in  1  system clock, the single clock of the block
- `rst`  in  1  synchronous, active-high reset
- `spi_sck`  in  1  SPI clock, asynchronous to `clk`
- `spi_sdi`  in  1  serial data from the controller
- `spi_sen_n`  in  1  active-low frame enable
- `spi_sdo`  out  1  serial readback data
- `wr_valid`  out  1  one-cycle pulse when a register write commits
- `wr_addr`  out  8  address of the committed write
- `wr_data`  out  16  data of the committed write
- `frame_err`  out  1  one-cycle pulse when a frame ends with a bit count other than 24
- `soft_reset`  out  1  one-cycle pulse when RESET[0] is written
- `trim_loaded`  out  1  sticky flag, set when register 0x30 bit 1 is written as 1
- `dbg_addr`  in  8  host debug read address
- `dbg_rdata`  out  16  register contents at `dbg_addr`, registered

## Operation
- Synchronization:
  - `spi_sck`, `spi_sdi` and `spi_sen_n` each pass through a 2-FF synchronizer.
  - SCK rising and falling edges are detected on the synchronized value.
  - SDI is sampled from the same pipeline stage as the SCK it pairs with.
- FSM states:
  - IDLE: SEN high. On SEN falling go to ADDR and clear the bit counter.
  - ADDR: shift in on each SCK rise. After the 8th bit, latch `addr` and go to DATA.
  - DATA: shift in on each SCK rise. Bits beyond 24 are ignored and mark the frame overlong.
  - DONE: entered on SEN rising from ADDR or DATA. Commit or error for one cycle, then IDLE.
  - WAIT_IDLE: entered after reset. Stays until synchronized SEN is seen high, then IDLE. A frame already in progress at reset is never decoded.
- Commit on DONE with exactly 24 bits:
  - Read mode clear (reg 0x00 bit 1 = 0): write `regs[addr] = data` unless `addr == RO_MASK_ADDR`, and pulse `wr_valid`.
  - Read mode set: only address 0x00 is writable. Frames to other addresses are reads and change nothing.
  - Address 0x00 with bit 0 set:
    - Pulse `soft_reset` and clear all registers, including `trim_loaded`.
    - The stored value of reg 0x00 is `data & 16'hFFFE`, so RESET is self-clearing.
    - This clear is applied after the write, so it also wipes read mode.
  - Address 0x30 with bit 1 set: set `trim_loaded`.
- Commit on DONE with a bit count ≠ 24: pulse `frame_err` and write nothing.
- Readback (read mode set):
  - At the SCK falling edge that follows the 8th rise, `spi_sdo` drives bit 15 of `regs[addr]`.
  - Each later falling edge shifts out the next bit, down to bit 0.
  - Outside the data phase, or with read mode clear, `spi_sdo` = 0.
- Debug port: `dbg_rdata <= regs[dbg_addr]` every cycle. A same-cycle commit is visible one cycle later.

## Timing
- Reset values:
  - `spi_sdo`, `wr_valid`, `frame_err`, `soft_reset`, `trim_loaded` = 0.
  - `wr_addr` = 0, `wr_data` = 0, `dbg_rdata` = 0.
  - All registers = 0; FSM in WAIT_IDLE.
- Edge latency: 3 `clk` from a pin transition to the internal edge strobe (2 synchronizer stages + edge detect).
- SDO latency: falling-edge strobe + 1 `clk` to SDO register, about 4 `clk` (40 ns at 100 MHz). This fits within half of a 10 MHz SCK period, so the controller sees valid data at its next rise.
- Commit latency: `wr_valid`, `wr_addr` and `wr_data` update 4 `clk` after the SEN rising pin edge. `wr_addr`/`wr_data` hold until the next commit.
- SEN rising and an SCK edge detected in the same cycle: SEN wins and the edge is discarded.
- SEN pulses high for fewer than 2 `clk`: may be missed. The controller guarantees ≥ 1 SCK period of SEN high.
- `rst` asserted mid-frame: all outputs return to reset values the next cycle.

## Test plan
- Write frame 0x10ABCD → `wr_valid` pulse with `wr_addr`=0x10, `wr_data`=0xABCD; then `dbg_addr`=0x10 gives `dbg_rdata`=0xABCD.
- Write 0x10ABCD, then 0x000001 → `soft_reset` pulse; `dbg_rdata` at 0x10 = 0x0000; reg 0x00 = 0x0000.
- Write 0x300002 → `trim_loaded`=1 and it stays 1. Then 0x000001 → `trim_loaded`=0.
- Write 0x10ABCD, then 0x000002 (read mode), then frame 0x101234 → the bench captures 0xABCD on SDO at SCK rises 9–24; reg 0x10 stays 0xABCD; no `wr_valid` for the read frame.
- Frame truncated to 12 bits, and frame of 25 bits → `frame_err` pulse for each, no `wr_valid`, registers unchanged. A following valid 0x11BEEF commits normally.
- `rst` pulsed after SCK rise 10 of a 0x12CAFE frame → that frame is ignored (no `wr_valid`, no `frame_err`). The next full frame 0x13BEEF commits.

Source files
------------

// File: rtl/afe2256_spi_target.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : afe2256_spi_target                                            |
// | Description : AFE2256-style SPI register target, oversampled in clk domain. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module afe2256_spi_target #(
    parameter int          CLK_FREQ_MHZ = 100,
    parameter logic [7:0]  RO_MASK_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_sdi,
    input  logic        spi_sen_n,
    output logic        spi_sdo,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic        soft_reset,
    output logic        trim_loaded,
    input  logic [7:0]  dbg_addr,
    output logic [15:0] dbg_rdata
);

    localparam logic [4:0] c_FRAME_BITS = 5'd24;
    localparam logic [4:0] c_ADDR_LAST  = 5'd7;

    if (CLK_FREQ_MHZ < 8) begin : g_clk_check
        $error("afe2256_spi_target: CLK_FREQ_MHZ too low for SCK oversampling");
    end

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_ADDR      = 3'd2,
        S_DATA      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t       state_q;
    logic [2:0]   sck_q;
    logic [2:0]   sen_q;
    logic [1:0]   sdi_q;
    logic [4:0]   bit_cnt_q;
    logic         overlong_q;
    logic [7:0]   addr_q;
    logic [15:0]  data_q;
    logic [15:0]  rd_sr_q;
    logic [15:0]  regs_q [256];

    logic         w_sck_rise;
    logic         w_sck_fall;
    logic         w_sen_rise;
    logic         w_sdi;
    logic [7:0]   w_addr_next;
    logic         w_read_mode;
    logic         w_len_ok;
    logic         w_do_write;
    logic         w_do_sreset;
    logic         w_do_trim;

    // Stage [1] is the second synchronizer flop; stage [2] is kept only for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q <= '0;
            sen_q <= '0;
            sdi_q <= '0;
        end else begin
            sck_q <= {sck_q[1:0], spi_sck};
            sen_q <= {sen_q[1:0], spi_sen_n};
            sdi_q <= {sdi_q[0], spi_sdi};
        end
    end

    always_comb begin
        w_sck_rise  = sck_q[1] & ~sck_q[2];
        w_sck_fall  = ~sck_q[1] & sck_q[2];
        w_sen_rise  = sen_q[1] & ~sen_q[2];
        w_sdi       = sdi_q[1];
        w_addr_next = {addr_q[6:0], w_sdi};
        w_read_mode = regs_q[0][1];
        w_len_ok    = (bit_cnt_q == c_FRAME_BITS) && !overlong_q;
        w_do_write  = w_len_ok && (!w_read_mode || addr_q == 8'h00) && (addr_q != RO_MASK_ADDR);
        w_do_sreset = w_do_write && (addr_q == 8'h00) && data_q[0];
        w_do_trim   = w_do_write && (addr_q == 8'h30) && data_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT_IDLE;
            bit_cnt_q   <= '0;
            overlong_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rd_sr_q     <= '0;
            spi_sdo     <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_err   <= 1'b0;
            soft_reset  <= 1'b0;
            trim_loaded <= 1'b0;
            dbg_rdata   <= '0;
            for (int i = 0; i < 256; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_valid   <= 1'b0;
            frame_err  <= 1'b0;
            soft_reset <= 1'b0;
            dbg_rdata  <= regs_q[dbg_addr];

            case (state_q)
                // A frame cut by reset must finish before anything is decoded.
                S_WAIT_IDLE: begin
                    spi_sdo <= 1'b0;
                    if (sen_q[1]) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    spi_sdo    <= 1'b0;
                    bit_cnt_q  <= '0;
                    overlong_q <= 1'b0;
                    if (!sen_q[1]) begin
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    spi_sdo <= 1'b0;
                    if (w_sen_rise) begin
                        state_q <= S_DONE;
                    end else if (w_sck_rise) begin
                        addr_q    <= w_addr_next;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == c_ADDR_LAST) begin
                            state_q <= S_DATA;
                            rd_sr_q <= w_read_mode ? regs_q[w_addr_next] : 16'h0000;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sen_rise) begin
                        state_q <= S_DONE;
                        spi_sdo <= 1'b0;
                    end else if (w_sck_rise) begin
                        if (bit_cnt_q == c_FRAME_BITS) begin
                            overlong_q <= 1'b1;
                        end else begin
                            data_q    <= {data_q[14:0], w_sdi};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end else if (w_sck_fall) begin
                        spi_sdo <= rd_sr_q[15];
                        rd_sr_q <= {rd_sr_q[14:0], 1'b0};
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    spi_sdo <= 1'b0;
                    if (!w_len_ok) begin
                        frame_err <= 1'b1;
                    end else if (w_do_write) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= addr_q;
                        wr_data  <= data_q;
                        // RESET wipes the whole file, including the word just written.
                        if (w_do_sreset) begin
                            soft_reset  <= 1'b1;
                            trim_loaded <= 1'b0;
                            for (int i = 0; i < 256; i++) begin
                                regs_q[i] <= '0;
                            end
                        end else begin
                            regs_q[addr_q] <= data_q;
                            if (w_do_trim) begin
                                trim_loaded <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_WAIT_IDLE;
                    spi_sdo <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_afe2256_spi_target.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_afe2256_spi_target                                         |
// | Description : Randomized SPI frames checked against a register-file model.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_afe2256_spi_target;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_sdi = 1'b0;
    logic        spi_sen_n = 1'b1;
    logic [7:0]  dbg_addr = 8'h00;
    logic        spi_sdo;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic        soft_reset;
    logic        trim_loaded;
    logic [15:0] dbg_rdata;

    afe2256_spi_target #(.CLK_FREQ_MHZ(100), .RO_MASK_ADDR(8'hFF)) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .spi_sen_n(spi_sen_n), .spi_sdo(spi_sdo), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err),
        .soft_reset(soft_reset), .trim_loaded(trim_loaded),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad = 0;
    logic [15:0] m_regs [256];
    logic        m_trim;
    bit          chk_en = 1'b0;
    logic [7:0]  dbg_prev = 8'h00;

    int          w_wr, w_err, w_sr, w_lat;
    logic [7:0]  w_addr;
    logic [15:0] w_data;
    logic [15:0] sdo_cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_regs[i] = 16'h0000;
        m_trim = 1'b0;
    endtask

    // ewr: 1 write expected, 0 none, -1 not checked (read-only address)
    task automatic model_frame(input logic [7:0] a, input logic [15:0] d, input int nbits,
                               output int ewr, output int eerr, output int esr);
        ewr = 0; eerr = 0; esr = 0;
        if (nbits != 24) begin
            eerr = 1;
            return;
        end
        if (m_regs[0][1] && a != 8'h00) return;
        if (a == 8'hFF) begin
            ewr = -1;
            return;
        end
        ewr = 1;
        m_regs[a] = d;
        if (a == 8'h30 && d[1]) m_trim = 1'b1;
        if (a == 8'h00 && d[0]) begin
            model_reset();
            esr = 1;
        end
    endtask

    task automatic frame(input logic [7:0] a, input logic [15:0] d, input int nbits, input int rst_at);
        logic [31:0] v;
        logic [15:0] exp_sdo;
        int ewr, eerr, esr;
        v = {a, d, 8'($urandom)};
        exp_sdo = m_regs[0][1] ? m_regs[a] : 16'h0000;
        chk_en = 1'b0;
        sdo_cap = 16'h0000;
        spi_sen_n = 1'b0;
        ticks(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = v[31-i];
            ticks(HALF);
            if (i >= 8 && i < 24) sdo_cap[23-i] = spi_sdo;
            spi_sck = 1'b1;
            ticks(HALF);
            if (rst_at == i + 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                model_reset();
                chk("rst trim_loaded", 32'(trim_loaded), 32'h0);
                chk("rst wr_addr", 32'(wr_addr), 32'h0);
                chk("rst wr_data", 32'(wr_data), 32'h0);
                chk("rst spi_sdo", 32'(spi_sdo), 32'h0);
                chk("rst dbg_rdata", 32'(dbg_rdata), 32'h0);
            end
            spi_sck = 1'b0;
        end
        ticks(HALF);
        spi_sen_n = 1'b1;
        w_wr = 0; w_err = 0; w_sr = 0; w_lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (wr_valid) begin
                w_wr++;
                w_addr = wr_addr;
                w_data = wr_data;
                if (w_lat == 0) w_lat = k;
            end
            if (frame_err) begin
                w_err++;
                if (w_lat == 0) w_lat = k;
            end
            if (soft_reset) w_sr++;
        end
        if (rst_at == 0) begin
            model_frame(a, d, nbits, ewr, eerr, esr);
        end else begin
            ewr = 0; eerr = 0; esr = 0;
        end
        if (ewr >= 0) chk("wr_valid count", 32'(w_wr), 32'(ewr));
        if (ewr == 1) begin
            chk("wr_addr", 32'(w_addr), 32'(a));
            if (esr == 0) chk("wr_data", 32'(w_data), 32'(d));
        end
        chk("frame_err count", 32'(w_err), 32'(eerr));
        chk("soft_reset count", 32'(w_sr), 32'(esr));
        if (ewr == 1 || eerr == 1) chk("commit latency", 32'(w_lat), 32'd4);
        if (nbits >= 24 && rst_at == 0) chk("sdo readback", 32'(sdo_cap), 32'(exp_sdo));
        chk_en = 1'b1;
        ticks(8);
    endtask

    // Continuous idle-time comparison against the model.
    always @(posedge clk) dbg_prev <= dbg_addr;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("dbg_rdata", 32'(dbg_rdata), 32'(m_regs[dbg_prev]));
            chk("trim_loaded", 32'(trim_loaded), 32'(m_trim));
            chk("idle pulses", 32'({wr_valid, frame_err, soft_reset}), 32'h0);
            chk("idle spi_sdo", 32'(spi_sdo), 32'h0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dbg_addr = ($urandom_range(0, 1) == 1) ? {4'h1, 4'($urandom)} : 8'($urandom);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra;
        int r;
        model_reset();
        rst = 1'b1;
        ticks(4);
        chk("reset outputs", 32'({spi_sdo, wr_valid, frame_err, soft_reset, trim_loaded}), 32'h0);
        chk("reset wr_addr/wr_data", 32'({wr_addr, wr_data}), 32'h0);
        chk("reset dbg_rdata", 32'(dbg_rdata), 32'h0);
        rst = 1'b0;
        ticks(6);
        chk_en = 1'b1;
        ticks(10);

        frame(8'h10, 16'hABCD, 24, 0);
        chk("lit wr_addr 10", 32'(w_addr), 32'h10);
        chk("lit wr_data ABCD", 32'(w_data), 32'hABCD);
        frame(8'h00, 16'h0001, 24, 0);
        chk("lit soft_reset", 32'(w_sr), 32'd1);

        frame(8'h30, 16'h0002, 24, 0);
        chk("lit trim set", 32'(trim_loaded), 32'd1);
        frame(8'h10, 16'hABCD, 24, 0);
        chk("lit trim sticky", 32'(trim_loaded), 32'd1);
        frame(8'h00, 16'h0001, 24, 0);
        chk("lit trim cleared", 32'(trim_loaded), 32'd0);

        frame(8'h10, 16'hABCD, 24, 0);
        frame(8'h00, 16'h0002, 24, 0);
        frame(8'h10, 16'h1234, 24, 0);
        chk("lit readback ABCD", 32'(sdo_cap), 32'hABCD);
        chk("lit read no wr", 32'(w_wr), 32'd0);
        frame(8'h00, 16'h0000, 24, 0);

        frame(8'h20, 16'h1111, 12, 0);
        chk("lit short err", 32'(w_err), 32'd1);
        frame(8'h20, 16'h2222, 25, 0);
        chk("lit long err", 32'(w_err), 32'd1);
        frame(8'h11, 16'hBEEF, 24, 0);
        chk("lit wr_data BEEF", 32'(w_data), 32'hBEEF);

        frame(8'h30, 16'h0002, 24, 0);
        frame(8'h12, 16'hCAFE, 24, 10);
        chk("lit rst frame no wr", 32'(w_wr + w_err), 32'd0);
        frame(8'h13, 16'hBEEF, 24, 0);
        chk("lit wr_addr 13", 32'(w_addr), 32'h13);

        frame(8'hFF, 16'h5555, 24, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 254)) : {4'h1, 4'($urandom)};
            if (ra == 8'h30) ra = 8'h31;
            if (r < 60)      frame(ra, 16'($urandom), 24, 0);
            else if (r < 70) frame(8'h00, (16'($urandom) & 16'hFFFC) | 16'h0002, 24, 0);
            else if (r < 78) frame(8'h00, 16'($urandom) & 16'hFFFC, 24, 0);
            else if (r < 83) frame(8'h00, 16'($urandom) | 16'h0001, 24, 0);
            else if (r < 88) frame(8'h30, 16'($urandom) | 16'h0002, 24, 0);
            else if ($urandom_range(0, 1) == 1) frame(ra, 16'($urandom), $urandom_range(1, 23), 0);
            else frame(ra, 16'($urandom), $urandom_range(25, 28), 0);
        end

        chk_en = 1'b0;
        ticks(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
